// File: rtl/ahb_uart_tx.sv
// ahb_uart_tx: AHB-Lite slave that transmits written bytes as 8N1 UART frames
module ahb_uart_tx #(
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        TX
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic        dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [1:0]  dp_addr_q, dp_addr_d;
  logic [7:0]  data_q, data_d, shift_q, shift_d;
  logic [15:0] dvdr_q, dvdr_d, div_q, div_d, baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        wr, wr_data, wr_dvdr, rd, busy, bit_end;
  logic        unused;
  assign unused  = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};
  assign HREADY  = 1'b1;
  assign HRESP   = 1'b0;
  assign wr      = dp_valid_q & dp_write_q;
  assign wr_data = wr & (dp_addr_q == 2'd0);
  assign wr_dvdr = wr & (dp_addr_q == 2'd2);
  assign rd      = dp_valid_q & ~dp_write_q;
  assign busy    = state_q != IDLE;
  assign bit_end = baud_q == div_q - 16'd1;
  assign TX      = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
  assign HRDATA  = !rd                ? 32'd0 :
                   dp_addr_q == 2'd0 ? {24'd0, data_q} :
                   dp_addr_q == 2'd1 ? {31'd0, busy} :
                   dp_addr_q == 2'd2 ? {16'd0, dvdr_q} : 32'd0;
  // address phase capture for the following data phase
  always_comb begin
    dp_valid_d = HSEL & HTRANS[1] & HREADY;
    dp_addr_d  = HADDR[3:2];
    dp_write_d = HWRITE;
  end
  // register writes, frame sequencing and baud/bit counting
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = wr_data ? HWDATA[7:0] : data_q;
    dvdr_d  = wr_dvdr ? HWDATA[15:0] : dvdr_q;
    if (busy) baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    case (state_q)
      IDLE:  state_d = IDLE;
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP:  state_d = bit_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    if (wr_data && (state_q == IDLE || (state_q == STOP && bit_end))) begin
      state_d = START;
      shift_d = HWDATA[7:0];
      div_d   = dvdr_q == 16'd0 ? 16'd1 : dvdr_q;
      baud_d  = 16'd0;
      bit_d   = 3'd0;
    end
  end
  // state registers; reset aborts any frame in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 2'd0;
      data_q     <= 8'd0;
      shift_q    <= 8'd0;
      dvdr_q     <= DIV_RESET;
      div_q      <= 16'd1;
      baud_q     <= 16'd0;
      bit_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
      dvdr_q     <= dvdr_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
    end
  end
endmodule

// File: doc/ahb_uart_tx.md
AHB_UART_TX -- requirements
Module: ahb_uart_tx

Interface
REQ-001 SHALL provide parameter DIV_RESET, default 16'd434, reset value of the divider register (bit period in HCLK cycles).
REQ-002 SHALL provide HCLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide HRESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide HSEL  input  1  slave select from the address decoder (0xbf400000 region).
REQ-005 SHALL provide HADDR  input  32  byte address; only HADDR[3:2] decoded.
REQ-006 SHALL provide HTRANS  input  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) marks a valid transfer.
REQ-007 SHALL provide HWRITE  input  1  1=write, 0=read.
REQ-008 SHALL provide HSIZE  input  3  accepted, ignored; every access is treated as a word access.
REQ-009 SHALL provide HWDATA  input  32  write data, valid in the data phase.
REQ-010 SHALL provide HRDATA  output  32  read data, valid in the data phase.
REQ-011 SHALL provide HREADY  output  1  tied 1 (zero wait states).
REQ-012 SHALL provide HRESP  output  1  tied 0 (OKAY).
REQ-013 SHALL provide TX  output  1  serial line, idle high.

Function
REQ-014 Address phase SHALL be accepted when HSEL & HTRANS[1] & HREADY; HADDR[3:2] and HWRITE SHALL be registered for the following data phase.
REQ-015 Register map (offset): 0x0 DATA, RW, bits[7:0] = last byte written, bits[31:8] read 0.
REQ-016 Register map: 0x4 CTRL, RO, bit0 = busy, bits[31:1] read 0; writes ignored.
REQ-017 Register map: 0x8 DVDR, RW, bits[15:0] = divider, bits[31:16] read 0.
REQ-018 Offset 0xC SHALL read 0; writes to it SHALL be ignored, with no error response.
REQ-019 Write data SHALL be captured from HWDATA at the rising edge that ends the data phase.
REQ-020 HRDATA SHALL be driven combinationally during the data phase from the registered offset and current register state; it SHALL be 0 outside a read data phase.
REQ-021 A DATA write while idle SHALL load the byte and start a frame at that same edge: busy=1 and TX=0 from that edge.
REQ-022 A DATA write while busy SHALL update the DATA readback value only, SHALL NOT affect the frame in flight, and SHALL NOT be queued.
REQ-023 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on an accepted DATA write; START->DATA after D cycles; DATA->STOP after 8 bits; STOP->IDLE after D cycles.
REQ-024 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit SHALL last exactly D HCLK cycles.
REQ-025 D SHALL be the DVDR value latched at frame start; a DVDR value of 0 SHALL be treated as D=1.
REQ-026 A DVDR write during a frame SHALL be stored and apply from the next frame only.
REQ-027 busy SHALL be 1 for exactly 10*D cycles per frame and clear at the edge where the stop bit ends; TX SHALL be 1 in IDLE.
REQ-028 A DATA write accepted in the same cycle busy clears (IDLE) SHALL start a new frame with no idle gap.
REQ-029 Internal counters SHALL be a 16-bit baud counter and a 3-bit bit index; neither SHALL wrap mid-bit.

Reset
REQ-030 While HRESET=1: TX=1, busy=0, FSM=IDLE, DATA=0, DVDR=DIV_RESET, counters=0, registered address phase cleared; HRDATA=0.
REQ-031 Assertion of HRESET mid-frame SHALL abort the frame immediately (asynchronously), with TX returning to 1.
REQ-032 Operation SHALL resume on the first HCLK edge after HRESET deasserts.

Verification
REQ-033 Reset, then read 0x8 -> 434; read 0x4 -> 0; TX=1.
REQ-034 Write 0x8=2, then write 0x0=0xAA -> TX = 0,0,1,0,1,0,1,0,1,1 (start, LSB first, stop), each bit 2 cycles; busy=1 for 20 cycles.
REQ-035 Poll 0x4 until bit0=0, then write 0xCC -> second frame starts on that edge; reading 0x0 returns 0xCC.
REQ-036 Write 0x99 while busy with 0xCC -> 0xCC frame is unchanged and no 0x99 frame is sent; reading 0x0 returns 0x99.
REQ-037 Write 0x8=0, then send 0x55 -> 1 cycle per bit; write 0x8=4 mid-frame -> current frame stays at 1 cycle per bit, next frame uses 4.
REQ-038 Assert HRESET at cycle 5 of a frame -> TX=1 and busy=0 immediately; after release, read 0x8 -> 434.
